rst_seq: RTL and testbench



---
 rtl/rst_seq_if.sv | 39 +++
 rtl/rst_seq.sv | 161 ++++++++++++++++
 tb/tb_rst_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// rst_seq_if: groups the reset sequencer's request/acknowledge and reset outputs.
//
// Signals:
//   soft_rst_req  level request for a sequenced soft reset (slave -> master)
//   wdt_kick      watchdog restart pulse (slave -> master)
//   soft_rst_ack  soft-reset acknowledge (master -> slave)
//   rst_out_n     active-low stage resets, bit 0 releases first (master -> slave)
//   seq_done      high once every stage is released (master -> slave)
//   rst_cause     cause of the last sequence: 01 ext, 10 soft, 11 watchdog
//
// Modports: master = the sequencer, slave = the consumer of the resets.
interface rst_seq_if #(
    parameter int unsigned NUM_STAGES = 4
) ();
    logic                  soft_rst_req;
    logic                  wdt_kick;
    logic                  soft_rst_ack;
    logic [NUM_STAGES-1:0] rst_out_n;
    logic                  seq_done;
    logic [1:0]            rst_cause;

    modport master (
        input  soft_rst_req,
        input  wdt_kick,
        output soft_rst_ack,
        output rst_out_n,
        output seq_done,
        output rst_cause
    );

    modport slave (
        output soft_rst_req,
        output wdt_kick,
        input  soft_rst_ack,
        input  rst_out_n,
        input  seq_done,
        input  rst_cause
    );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Synchronizes release of the raw asynchronous reset,
// stretches it, then releases NUM_STAGES active-low stage resets in order spaced
// by STAGE_GAP cycles. A four-phase soft-reset handshake re-runs the sequence from
// the stretch phase.
//
// Optional feature: define RST_SEQ_WDT_EN to build a watchdog that re-runs the
// sequence (cause 11) when no wdt_kick arrives for WDT_CYCLES cycles in RUN.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   rst_seq_if.master: soft_rst_req/wdt_kick in; soft_rst_ack, rst_out_n,
//         seq_done, rst_cause out (all registered)
//
// Parameter limits: NUM_STAGES >= 1, SYNC_STAGES >= 2, STRETCH_CYCLES >= 1,
// STAGE_GAP >= 1.
module rst_seq #(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned WDT_CYCLES     = 1000
) (
    input  logic      clk,
    input  logic      rst,
    rst_seq_if.master bus
);
    // One counter serves both the stretch phase and the inter-stage gap.
    localparam int unsigned CntMax = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned IdxW   = $clog2(NUM_STAGES + 1);

    typedef enum logic [2:0] {
        StHold,
        StStretch,
        StRelease,
        StRun,
        StSoftAssert
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [CntW-1:0]         cnt_q;
    logic [IdxW-1:0]         idx_q;      // next stage to release
    logic [NUM_STAGES-1:0]   rst_out_n_q;
    logic                    seq_done_q;
    logic                    soft_rst_ack_q;
    logic [1:0]              rst_cause_q;

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    logic [WdtW-1:0] wdt_q;
`else
    logic unused_wdt;
    assign unused_wdt = bus.wdt_kick & (WDT_CYCLES != 0);
`endif

    function automatic logic [NUM_STAGES-1:0] stage_bit(input logic [IdxW-1:0] idx);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (idx == IdxW'(k)) m[k] = 1'b1;
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StHold;
            sync_q         <= '0;
            cnt_q          <= '0;
            idx_q          <= '0;
            rst_out_n_q    <= '0;
            seq_done_q     <= 1'b0;
            soft_rst_ack_q <= 1'b0;
            rst_cause_q    <= 2'b01;
`ifdef RST_SEQ_WDT_EN
            wdt_q          <= '0;
`endif
        end else begin
            // Release of rst only reaches the FSM through this shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};

            unique case (state_q)
                StHold: begin
                    if (sync_q[SYNC_STAGES-1]) begin
                        state_q <= StStretch;
                        cnt_q   <= '0;
                    end
                end

                StStretch: begin
                    if (cnt_q == CntW'(STRETCH_CYCLES - 1)) begin
                        state_q     <= StRelease;
                        cnt_q       <= '0;
                        idx_q       <= IdxW'(1);
                        rst_out_n_q <= NUM_STAGES'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRelease: begin
                    if (idx_q == IdxW'(NUM_STAGES)) begin
                        state_q    <= StRun;
                        seq_done_q <= 1'b1;
`ifdef RST_SEQ_WDT_EN
                        wdt_q      <= '0;
`endif
                    end else if (cnt_q == CntW'(STAGE_GAP - 1)) begin
                        rst_out_n_q <= rst_out_n_q | stage_bit(idx_q);
                        idx_q       <= idx_q + 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StRun: begin
                    // Soft request outranks both kick and timeout.
                    if (bus.soft_rst_req) begin
                        state_q        <= StSoftAssert;
                        rst_out_n_q    <= '0;
                        seq_done_q     <= 1'b0;
                        soft_rst_ack_q <= 1'b1;
                        rst_cause_q    <= 2'b10;
`ifdef RST_SEQ_WDT_EN
                    end else if (bus.wdt_kick) begin
                        wdt_q <= '0;
                    end else if (wdt_q == WdtW'(WDT_CYCLES - 1)) begin
                        state_q     <= StStretch;
                        cnt_q       <= '0;
                        rst_out_n_q <= '0;
                        seq_done_q  <= 1'b0;
                        rst_cause_q <= 2'b11;
                    end else begin
                        wdt_q <= wdt_q + 1'b1;
`endif
                    end
                end

                StSoftAssert: begin
                    if (!bus.soft_rst_req) begin
                        state_q        <= StStretch;
                        cnt_q          <= '0;
                        soft_rst_ack_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign bus.rst_out_n    = rst_out_n_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.soft_rst_ack = soft_rst_ack_q;
    assign bus.rst_cause    = rst_cause_q;
endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: a table of timing checkpoints for power-on,
// hand-written sequences for mid-sequence reset, soft reset and the watchdog
// option, and a randomized phase checked every cycle against a timeline model.
module tb_rst_seq;
    localparam int N       = 4;
    localparam int SYNC    = 2;
    localparam int STRETCH = 16;
    localparam int GAP     = 8;
    localparam int WDT     = 50;

    logic clk;
    logic rst;

    rst_seq_if #(.NUM_STAGES(N)) sif ();

    rst_seq #(
        .NUM_STAGES    (N),
        .SYNC_STAGES   (SYNC),
        .STRETCH_CYCLES(STRETCH),
        .STAGE_GAP     (GAP),
        .WDT_CYCLES    (WDT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: expected outputs follow from absolute edge numbers.
    int         g         = 0;   // global rising-edge count
    int         rel_edges = 0;   // edges since rst was released
    bit         m_rst     = 1'b1;
    bit         m_soft    = 1'b0;
    int         rel_at    = 0;   // edge at which rst_out_n[0] rises
    int         done_at   = 0;   // edge at which seq_done rises
    int         wd_ref    = 0;   // last edge that restarted the watchdog
    logic [1:0] m_cause   = 2'b01;

    function automatic void restart_at(input int e);
        rel_at  = e;
        done_at = rel_at + (N - 1) * GAP + 1;
        wd_ref  = done_at;
    endfunction

    function automatic void model_edge(input logic req, input logic kick);
        g++;
        if (m_rst) return;
        rel_edges++;
        if (m_soft) begin
            if (!req) begin
                m_soft = 1'b0;
                restart_at(g + STRETCH);
            end
        end else if (g > done_at) begin
            if (req) begin
                m_soft  = 1'b1;
                m_cause = 2'b10;
            end
`ifdef RST_SEQ_WDT_EN
            else if (kick) begin
                wd_ref = g;
            end else if (g - wd_ref == WDT) begin
                m_cause = 2'b11;
                restart_at(g + STRETCH);
            end
`else
            else if (kick) begin
                wd_ref = g;
            end
`endif
        end
    endfunction

    function automatic logic [7:0] model_out();
        logic [N-1:0] b;
        if (m_rst) return 8'b0000_0001;
        if (m_soft) return {4'b0000, 1'b0, 1'b1, m_cause};
        for (int k = 0; k < N; k++) b[k] = (g >= rel_at + k * GAP);
        return {b, (g >= done_at), 1'b0, m_cause};
    endfunction

    function automatic logic [7:0] dut_out();
        return {sif.rst_out_n, sif.seq_done, sif.soft_rst_ack, sif.rst_cause};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: {rst_out_n,done,ack,cause} got %b want %b (rel edge %0d)",
                     name, act, exp, rel_edges);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(sif.soft_rst_req, sif.wdt_kick);
        #1;
        check("model", dut_out(), model_out());
    endtask

    task automatic run_to(input int e);
        while (rel_edges < e) step();
    endtask

    task automatic do_reset(input int cycles);
        sif.soft_rst_req = 1'b0;
        sif.wdt_kick     = 1'b0;
        rst     = 1'b1;
        m_rst   = 1'b1;
        m_soft  = 1'b0;
        m_cause = 2'b01;
        #1;
        check("async reset", dut_out(), 8'b0000_0001);
        repeat (cycles) step();
        rst       = 1'b0;
        m_rst     = 1'b0;
        rel_edges = 0;
        restart_at(g + 1 + SYNC + STRETCH);
    endtask

    typedef struct {
        int         edge_no;
        logic       req;
        logic [3:0] exp_n;
        logic       exp_done;
        logic       exp_ack;
        logic [1:0] exp_cause;
    } vec_t;

    vec_t vec[12];

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0]  = '{1,  1'b1, 4'b0000, 1'b0, 1'b0, 2'b01};
        vec[1]  = '{5,  1'b1, 4'b0000, 1'b0, 1'b0, 2'b01};
        vec[2]  = '{10, 1'b1, 4'b0000, 1'b0, 1'b0, 2'b01};
        vec[3]  = '{18, 1'b0, 4'b0000, 1'b0, 1'b0, 2'b01};
        vec[4]  = '{19, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01};
        vec[5]  = '{26, 1'b0, 4'b0001, 1'b0, 1'b0, 2'b01};
        vec[6]  = '{27, 1'b0, 4'b0011, 1'b0, 1'b0, 2'b01};
        vec[7]  = '{35, 1'b0, 4'b0111, 1'b0, 1'b0, 2'b01};
        vec[8]  = '{42, 1'b0, 4'b0111, 1'b0, 1'b0, 2'b01};
        vec[9]  = '{43, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b01};
        vec[10] = '{44, 1'b0, 4'b1111, 1'b1, 1'b0, 2'b01};
        vec[11] = '{50, 1'b0, 4'b1111, 1'b1, 1'b0, 2'b01};

        rst              = 1'b0;
        sif.soft_rst_req = 1'b0;
        sif.wdt_kick     = 1'b0;
        #2;

        // Power-on; soft requests during HOLD/STRETCH must be ignored.
        do_reset(3);
        for (int i = 0; i < 12; i++) begin
            sif.soft_rst_req = vec[i].req;
            run_to(vec[i].edge_no);
            check($sformatf("vec%0d@%0d", i, vec[i].edge_no), dut_out(),
                  {vec[i].exp_n, vec[i].exp_done, vec[i].exp_ack, vec[i].exp_cause});
        end
        sif.soft_rst_req = 1'b0;

        // Reset mid-sequence aborts immediately and restarts with the same offsets.
        do_reset(2);
        run_to(30);
        check("pre-abort", dut_out(), 8'b0011_0_0_01);
        do_reset(1);
        run_to(18);
        check("restart e18", dut_out(), 8'b0000_0_0_01);
        run_to(19);
        check("restart e19", dut_out(), 8'b0001_0_0_01);
        run_to(44);
        check("restart done", dut_out(), 8'b1111_1_0_01);

        // Soft reset handshake.
        repeat (60) step();
        sif.soft_rst_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("soft hold %0d", i), dut_out(), 8'b0000_0_1_10);
        end
        sif.soft_rst_req = 1'b0;
        step();
        check("soft ack drop", dut_out(), 8'b0000_0_0_10);
        repeat (15) step();
        check("soft S+15", dut_out(), 8'b0000_0_0_10);
        step();
        check("soft S+16", dut_out(), 8'b0001_0_0_10);
        repeat (25) step();
        check("soft done", dut_out(), 8'b1111_1_0_10);

        // Randomized phase against the timeline model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 47) == 0) sif.soft_rst_req = ~sif.soft_rst_req;
            sif.wdt_kick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
            step();
        end

`ifdef RST_SEQ_WDT_EN
        do_reset(3);
        run_to(93);
        check("wdt e93", dut_out(), 8'b1111_1_0_01);
        run_to(94);
        check("wdt timeout", dut_out(), 8'b0000_0_0_11);
        run_to(110);
        check("wdt rerelease", dut_out(), 8'b0001_0_0_11);
        run_to(135);
        check("wdt redone", dut_out(), 8'b1111_1_0_11);
        for (int c = 0; c < 300; c++) begin
            sif.wdt_kick = ((c % 40) == 39);
            step();
        end
        sif.wdt_kick = 1'b0;
        check("wdt kicked", dut_out(), 8'b1111_1_0_11);
`else
        do_reset(3);
        sif.wdt_kick = 1'b0;
        run_to(44);
        repeat (2000) step();
        check("no watchdog", dut_out(), 8'b1111_1_0_01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
